axi_stream_rx_fifo: RTL and testbench

- AXI-Stream slave (receiver) endpoint: drives TREADY, accepts beats, buffers them in a first-word-fall-through FIFO and presents them on a simple pop interface.
- Tracks complete packets (TLAST-terminated) held in the buffer.
- Sits at the sink end of any AXI-Stream master in the design; the same master-side protocol properties hold on its slave port.

---
 rtl/axi_stream_pkg.sv | 33 +++
 rtl/axi_stream_rx_storage.sv | 23 ++
 rtl/axi_stream_rx_fifo.sv | 128 ++++++++++++
 tb/tb_axi_stream_rx_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared sizing helpers and the packed FIFO entry layout {last, user, keep, strb, data}
// for the AXI-Stream receive FIFO.
package axi_stream_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int data_lsb(input int bw);
    return 0 * bw;
  endfunction

  function automatic int strb_lsb(input int bw);
    return 8 * bw;
  endfunction

  function automatic int keep_lsb(input int bw);
    return 9 * bw;
  endfunction

  function automatic int user_lsb(input int bw);
    return 10 * bw;
  endfunction

  function automatic int last_bit(input int bw, input int uw);
    return 10 * bw + uw;
  endfunction

  function automatic int entry_width(input int bw, input int uw);
    return 10 * bw + uw + 1;
  endfunction

endpackage

// File: rtl/axi_stream_rx_storage.sv
// Simple dual-port register array: synchronous write, asynchronous read by address.
// No reset on the array; readers mask the output while nothing valid is stored.
module axi_stream_rx_storage #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(depth)-1:0] i_wr_addr,
  input  logic [width-1:0]         i_wr_data,
  input  logic [$clog2(depth)-1:0] i_rd_addr,
  output logic [width-1:0]         o_rd_data
);

  logic [width-1:0] r_mem [depth];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axi_stream_rx_fifo.sv
// AXI-Stream slave into a FWFT FIFO (1-cycle write-to-read), registered tready drops when full.
// Optional sticky protocol checker enabled by AXIS_RX_PROTOCOL_CHECK_EN.
module axi_stream_rx_fifo
  import axi_stream_pkg::*;
#(
  parameter int byte_width = 4,
  parameter int user_width = 1,
  parameter int depth      = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    tvalid,
  output logic                    tready,
  input  logic [8*byte_width-1:0] tdata,
  input  logic [byte_width-1:0]   tstrb,
  input  logic [byte_width-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [user_width-1:0]   tuser,
  output logic                    rd_valid,
  input  logic                    rd_en,
  output logic [8*byte_width-1:0] rd_data,
  output logic [byte_width-1:0]   rd_keep,
  output logic [byte_width-1:0]   rd_strb,
  output logic                    rd_last,
  output logic [user_width-1:0]   rd_user,
  output logic [$clog2(depth):0]  level,
  output logic [$clog2(depth):0]  pkt_count,
  output logic                    proto_err
);

  localparam int AW = $clog2(depth);
  localparam int CW = count_width(depth);
  localparam int EW = entry_width(byte_width, user_width);
  localparam int DW = 8 * byte_width;
  localparam int DL = data_lsb(byte_width);
  localparam int SL = strb_lsb(byte_width);
  localparam int KL = keep_lsb(byte_width);
  localparam int UL = user_lsb(byte_width);
  localparam int LB = last_bit(byte_width, user_width);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_level, r_pkt_count;
  logic          r_tready;
  logic [CW-1:0] w_level_nxt, w_pkt_nxt;
  logic          w_accept, w_push, w_pop, w_rd_valid, w_tready_nxt;
  logic          w_push_last, w_pop_last;
  logic [EW-1:0] w_wr_entry, w_rd_entry, w_head;

  // Null beats (no bytes, not end-of-packet) are consumed but never stored.
  assign w_accept   = tvalid & r_tready;
  assign w_push     = w_accept & ((|tkeep) | tlast);
  assign w_rd_valid = (r_level != '0);
  assign w_pop      = rd_en & w_rd_valid;
  assign w_wr_entry = {tlast, tuser, tkeep, tstrb, tdata};
  assign w_head     = w_rd_valid ? w_rd_entry : '0;

  assign w_push_last  = w_push & tlast;
  assign w_pop_last   = w_pop & w_head[LB];
  assign w_level_nxt  = r_level + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  assign w_pkt_nxt    = r_pkt_count + {{(CW-1){1'b0}}, w_push_last}
                                    - {{(CW-1){1'b0}}, w_pop_last};
  assign w_tready_nxt = (w_level_nxt < CW'(depth));

  axi_stream_rx_storage #(
    .width (EW),
    .depth (depth)
  ) u_storage (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_entry)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
      r_tready    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level     <= w_level_nxt;
      r_pkt_count <= w_pkt_nxt;
      r_tready    <= w_tready_nxt;
    end
  end

  assign tready    = r_tready;
  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_head[DL +: DW];
  assign rd_strb   = w_head[SL +: byte_width];
  assign rd_keep   = w_head[KL +: byte_width];
  assign rd_user   = w_head[UL +: user_width];
  assign rd_last   = w_head[LB];
  assign level     = r_level;
  assign pkt_count = r_pkt_count;

`ifdef AXIS_RX_PROTOCOL_CHECK_EN
  logic          r_stall, r_proto_err;
  logic [EW-1:0] r_prev_beat;
  logic          w_strb_err, w_hold_err;

  // A stalled beat must stay valid with every field unchanged on the next cycle.
  assign w_strb_err = tvalid & (|(tstrb & ~tkeep));
  assign w_hold_err = r_stall & (~tvalid | (w_wr_entry != r_prev_beat));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall     <= 1'b0;
      r_prev_beat <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_stall     <= tvalid & ~r_tready;
      r_prev_beat <= w_wr_entry;
      if (w_strb_err | w_hold_err) r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_rx_fifo.sv
// Self-checking bench: vector table for single-beat/null-beat/concurrency cases, scoreboarded
// fill/stall, reset mid-packet, protocol checks, and a randomised depth-4 stream.
module tb_axi_stream_rx_fifo;

`ifdef AXIS_RX_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // depth-16 instance
  logic        resetn, tvalid, tready, tlast, rd_valid, rd_en, rd_last, proto_err;
  logic [31:0] tdata, rd_data;
  logic [3:0]  tstrb, tkeep, rd_keep, rd_strb;
  logic [0:0]  tuser, rd_user;
  logic [4:0]  level, pkt_count;

  // depth-4 instance
  logic        b_resetn, b_tvalid, b_tready, b_tlast, b_rd_valid, b_rd_en, b_rd_last, b_proto_err;
  logic [31:0] b_tdata, b_rd_data;
  logic [3:0]  b_tstrb, b_tkeep, b_rd_keep, b_rd_strb;
  logic [0:0]  b_tuser, b_rd_user;
  logic [2:0]  b_level, b_pkt_count;

  axi_stream_rx_fifo #(.byte_width(4), .user_width(1), .depth(16)) u_dut (
    .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tuser(tuser), .rd_valid(rd_valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_keep(rd_keep), .rd_strb(rd_strb),
    .rd_last(rd_last), .rd_user(rd_user), .level(level), .pkt_count(pkt_count),
    .proto_err(proto_err)
  );

  axi_stream_rx_fifo #(.byte_width(4), .user_width(1), .depth(4)) u_dut4 (
    .clk(clk), .resetn(b_resetn), .tvalid(b_tvalid), .tready(b_tready), .tdata(b_tdata),
    .tstrb(b_tstrb), .tkeep(b_tkeep), .tlast(b_tlast), .tuser(b_tuser), .rd_valid(b_rd_valid),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_keep(b_rd_keep), .rd_strb(b_rd_strb),
    .rd_last(b_rd_last), .rd_user(b_rd_user), .level(b_level), .pkt_count(b_pkt_count),
    .proto_err(b_proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic [3:0]  tk;
    logic        tl;
    logic        re;
    logic [4:0]  lvl;
    logic [4:0]  pkt;
    logic        rv;
    logic [31:0] rdd;
    logic [3:0]  rk;
    logic        rl;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb [$];
  logic [32:0] bq [$];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  guard;
    int  sent;
    int  got;
    logic acc;

    //         tv  td            tk    tl  re   lvl pkt rv  rdd           rk    rl
    vecs[0] = '{0, 32'h0,        4'h0, 0,  0,   0,  0,  0,  32'h0,        4'h0, 0};
    vecs[1] = '{1, 32'hDEADBEEF, 4'hF, 1,  0,   1,  1,  1,  32'hDEADBEEF, 4'hF, 1};
    vecs[2] = '{0, 32'h0,        4'h0, 0,  1,   0,  0,  0,  32'h0,        4'h0, 0};
    vecs[3] = '{1, 32'h11111111, 4'h0, 0,  0,   0,  0,  0,  32'h0,        4'h0, 0};
    vecs[4] = '{1, 32'h22222222, 4'h0, 1,  0,   1,  1,  1,  32'h22222222, 4'h0, 1};
    vecs[5] = '{1, 32'hA1A1A1A1, 4'hF, 0,  1,   1,  0,  1,  32'hA1A1A1A1, 4'hF, 0};
    vecs[6] = '{0, 32'h0,        4'h0, 0,  1,   0,  0,  0,  32'h0,        4'h0, 0};
    vecs[7] = '{1, 32'hB2B2B2B2, 4'h3, 1,  1,   1,  1,  1,  32'hB2B2B2B2, 4'h3, 1};
    vecs[8] = '{0, 32'h0,        4'h0, 0,  1,   0,  0,  0,  32'h0,        4'h0, 0};

    resetn = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0; tkeep = '0; tlast = 1'b0;
    tuser = '0; rd_en = 1'b0;
    b_resetn = 1'b0; b_tvalid = 1'b0; b_tdata = '0; b_tstrb = '0; b_tkeep = '0;
    b_tlast = 1'b0; b_tuser = '0; b_rd_en = 1'b0;

    #12;
    check("rst_tready", tready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_proto_err", proto_err, 0);
    #8;
    resetn = 1'b1;
    b_resetn = 1'b1;
    cyc();
    check("tready_after_reset", tready, 1);

    foreach (vecs[i]) begin
      tvalid = vecs[i].tv; tdata = vecs[i].td; tkeep = vecs[i].tk; tstrb = vecs[i].tk;
      tlast = vecs[i].tl; rd_en = vecs[i].re;
      cyc();
      check($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d_pkt", i), pkt_count, vecs[i].pkt);
      check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].rv);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rdd);
      check($sformatf("vec%0d_rd_keep", i), rd_keep, vecs[i].rk);
      check($sformatf("vec%0d_rd_strb", i), rd_strb, vecs[i].rk);
      check($sformatf("vec%0d_rd_last", i), rd_last, vecs[i].rl);
      check($sformatf("vec%0d_tready", i), tready, 1);
    end
    tvalid = 1'b0; rd_en = 1'b0;

    // Fill to 16 with no pops.
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1; tdata = 32'h100 + i; tkeep = 4'hF; tstrb = 4'hF; tlast = (i == 15);
      check("fill_tready", tready, 1);
      if (tready) sb.push_back(tdata);
      cyc();
    end
    check("full_tready", tready, 0);
    check("full_level", level, 16);
    check("full_pkt", pkt_count, 1);

    // 17th beat held against backpressure.
    tdata = 32'h200; tlast = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("stall_tready", tready, 0);
      check("stall_level", level, 16);
      check("stall_proto_err", proto_err, 0);
    end
    tdata = 32'h201;
    cyc();
    check("hold_change_proto_err", proto_err, CHK);
    check("hold_change_level", level, 16);

    // One pop releases space; the held beat goes in on the following edge.
    check("pop_full_head", rd_data, sb.pop_front());
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("after_pop_level", level, 15);
    check("after_pop_tready", tready, 1);
    if (tready) sb.push_back(tdata);
    cyc();
    tvalid = 1'b0; tlast = 1'b0;
    check("beat17_level", level, 16);
    check("beat17_tready", tready, 0);
    check("beat17_pkt", pkt_count, 2);
    check("sticky_proto_err", proto_err, CHK);

    guard = 0;
    while (rd_valid && guard < 40) begin
      guard++;
      if (sb.size() == 0) check("drain_extra_entry", 1, 0);
      else check("drain_data", rd_data, sb.pop_front());
      rd_en = 1'b1;
      cyc();
    end
    rd_en = 1'b0;
    check("drain_level", level, 0);
    check("drain_pkt", pkt_count, 0);
    check("drain_sb_empty", sb.size(), 0);

    // Reset mid-packet: 3 of 5 beats in, then async reset between edges.
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 32'h300 + i; tkeep = 4'hF; tstrb = 4'hF; tlast = 1'b0;
      cyc();
    end
    tvalid = 1'b0;
    check("mid_pkt_level", level, 3);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_tready", tready, 0);
    check("async_rst_rd_valid", rd_valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_pkt", pkt_count, 0);
    check("async_rst_rd_data", rd_data, 0);
    check("async_rst_proto_err", proto_err, 0);
    #1;
    resetn = 1'b1;
    cyc();
    check("post_rst_tready", tready, 1);
    for (int i = 3; i < 5; i++) begin
      tvalid = 1'b1; tdata = 32'h300 + i; tkeep = 4'hF; tstrb = 4'hF; tlast = (i == 4);
      cyc();
    end
    tvalid = 1'b0; tlast = 1'b0;
    check("partial_level", level, 2);
    check("partial_pkt", pkt_count, 1);
    check("partial_head", rd_data, 32'h303);
    check("partial_head_last", rd_last, 0);

    // tstrb outside tkeep on a null beat.
    tvalid = 1'b1; tdata = 32'h400; tkeep = 4'h0; tstrb = 4'h1; tlast = 1'b0;
    cyc();
    tvalid = 1'b0; tstrb = 4'h0;
    check("strb_err_proto_err", proto_err, CHK);
    check("strb_err_null_dropped", level, 2);

    // Random concurrent push/pop on the depth-4 instance.
    sent = 0; got = 0; guard = 0;
    while ((sent < 100 || bq.size() != 0) && guard < 3000) begin
      guard++;
      if (!b_tvalid && sent < 100 && $urandom_range(0, 3) != 0) begin
        b_tvalid = 1'b1; b_tdata = $urandom(); b_tkeep = 4'hF; b_tstrb = 4'hF;
        b_tlast = 1'($urandom_range(0, 1));
      end
      b_rd_en = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      if (b_rd_en && b_rd_valid) begin
        if (bq.size() == 0) check("rand_unexpected_output", 1, 0);
        else check("rand_data", {b_rd_last, b_rd_data}, bq.pop_front());
        got++;
      end
      acc = b_tvalid && b_tready;
      if (acc) begin
        bq.push_back({b_tlast, b_tdata});
        sent++;
      end
      cyc();
      if (acc) b_tvalid = 1'b0;
      check("rand_level_max", (b_level > 3'd4), 0);
    end
    b_rd_en = 1'b0;
    check("rand_within_budget", (guard < 3000), 1);
    check("rand_got_count", got, 100);
    check("rand_queue_empty", bq.size(), 0);
    check("rand_final_level", b_level, 0);
    check("rand_final_pkt", b_pkt_count, 0);
    check("rand_proto_err", b_proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
